// File: rtl/uc_pkg.sv
//------------------------------------------------------------------------------
// Module      : uc_pkg
// Description : Shared opcode constants, FSM state type and widths for uc_fsm.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uc_pkg;

    localparam int ALU_OP_W   = 3;
    localparam int OP_ALU_BIT = 5;

    localparam logic [5:0] OP_NOP    = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JZ     = 6'b000011;
    localparam logic [5:0] OP_JNZ    = 6'b001000;
    localparam logic [5:0] OP_HALT   = 6'b001111;
    localparam logic [3:0] OP_LI_PFX = 4'b0001;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage : uc_pkg

`default_nettype wire

// File: rtl/uc_decode.sv
//------------------------------------------------------------------------------
// Module      : uc_decode
// Description : Combinational opcode/Z decode into datapath control signals.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0]          opcode_i,
    input  logic                z_i,
    output logic                s_inc_o,
    output logic                s_inm_o,
    output logic                we3_o,
    output logic                wez_o,
    output logic [ALU_OP_W-1:0] op_o,
    output logic                is_halt_o,
    output logic                is_illegal_o
);

    always_comb begin
        s_inc_o      = 1'b1;
        s_inm_o      = 1'b0;
        we3_o        = 1'b0;
        wez_o        = 1'b0;
        op_o         = '0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;

        if (opcode_i[OP_ALU_BIT]) begin
            we3_o = 1'b1;
            wez_o = 1'b1;
            op_o  = opcode_i[4:2];
        end else if (opcode_i[5:2] == OP_LI_PFX) begin
            we3_o   = 1'b1;
            s_inm_o = 1'b1;
        end else begin
            case (opcode_i)
                OP_NOP:  s_inc_o = 1'b1;
                OP_J:    s_inc_o = 1'b0;
                OP_JZ:   s_inc_o = ~z_i;
                OP_JNZ:  s_inc_o = z_i;
                OP_HALT: begin
                    // HALT's address field points at itself, so reloading parks the PC
                    s_inc_o   = 1'b0;
                    is_halt_o = 1'b1;
                end
                default: is_illegal_o = 1'b1;
            endcase
        end
    end

endmodule : uc_decode

`default_nettype wire

// File: rtl/uc_fsm.sv
//------------------------------------------------------------------------------
// Module      : uc_fsm
// Description : Control unit with RUN/HALT state, illegal flag and debug counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uc_fsm
    import uc_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter bit ILLEGAL_STICKY = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                z,
    input  logic                resume,
    output logic                s_inc,
    output logic                s_inm,
    output logic                we3,
    output logic                wez,
    output logic [ALU_OP_W-1:0] op,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [CNT_W-1:0]    halt_cycles
);

    state_t             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   halt_cycles_q, halt_cycles_d;

    logic                w_dec_s_inc;
    logic                w_dec_s_inm;
    logic                w_dec_we3;
    logic                w_dec_wez;
    logic [ALU_OP_W-1:0] w_dec_op;
    logic                w_dec_is_halt;
    logic                w_dec_is_illegal;
    logic                w_illegal_set;

    uc_decode u_decode (
        .opcode_i     (opcode),
        .z_i          (z),
        .s_inc_o      (w_dec_s_inc),
        .s_inm_o      (w_dec_s_inm),
        .we3_o        (w_dec_we3),
        .wez_o        (w_dec_wez),
        .op_o         (w_dec_op),
        .is_halt_o    (w_dec_is_halt),
        .is_illegal_o (w_dec_is_illegal)
    );

    always_comb begin
        state_d       = state_q;
        s_inc         = w_dec_s_inc;
        s_inm         = w_dec_s_inm;
        we3           = w_dec_we3;
        wez           = w_dec_wez;
        op            = w_dec_op;
        retired_d     = retired_q;
        halt_cycles_d = halt_cycles_q;

        case (state_q)
            RUN: begin
                if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
                // resume is deliberately ignored here so HALT always lasts one cycle
                if (w_dec_is_halt) state_d = HALT;
            end
            HALT: begin
                s_inc = resume;
                s_inm = 1'b0;
                we3   = 1'b0;
                wez   = 1'b0;
                op    = '0;
                if (halt_cycles_q != '1) halt_cycles_d = halt_cycles_q + CNT_W'(1);
                if (resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign w_illegal_set = (state_q == RUN) & w_dec_is_illegal;

    generate
        if (ILLEGAL_STICKY) begin : g_illegal_sticky
            assign illegal_d = illegal_q | w_illegal_set;
        end else begin : g_illegal_pulse
            assign illegal_d = w_illegal_set;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            illegal_q     <= 1'b0;
            retired_q     <= '0;
            halt_cycles_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            retired_q     <= retired_d;
            halt_cycles_q <= halt_cycles_d;
        end
    end

    assign halted      = (state_q == HALT);
    assign illegal     = illegal_q;
    assign retired     = retired_q;
    assign halt_cycles = halt_cycles_q;

endmodule : uc_fsm

`default_nettype wire

// File: tb/tb_uc_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_uc_fsm
// Description : Self-checking bench for uc_fsm (sticky/16-bit and pulse/4-bit builds).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uc_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       z = 1'b0;
    logic       resume = 1'b0;

    logic        s_inc_a, s_inm_a, we3_a, wez_a, halted_a, illegal_a;
    logic [2:0]  op_a;
    logic [15:0] retired_a, hc_a;
    logic        s_inc_b, s_inm_b, we3_b, wez_b, halted_b, illegal_b;
    logic [2:0]  op_b;
    logic [3:0]  retired_b, hc_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uc_fsm #(.CNT_W(16), .ILLEGAL_STICKY(1'b1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .resume(resume),
        .s_inc(s_inc_a), .s_inm(s_inm_a), .we3(we3_a), .wez(wez_a), .op(op_a),
        .halted(halted_a), .illegal(illegal_a), .retired(retired_a), .halt_cycles(hc_a)
    );

    uc_fsm #(.CNT_W(4), .ILLEGAL_STICKY(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .resume(resume),
        .s_inc(s_inc_b), .s_inm(s_inm_b), .we3(we3_b), .wez(wez_b), .op(op_b),
        .halted(halted_b), .illegal(illegal_b), .retired(retired_b), .halt_cycles(hc_b)
    );

    wire [6:0] ctrl_a = {s_inc_a, s_inm_a, we3_a, wez_a, op_a};
    wire [6:0] ctrl_b = {s_inc_b, s_inm_b, we3_b, wez_b, op_b};

    // Reference model: {s_inc, s_inm, we3, wez, op[2:0]} straight from the opcode table
    function automatic logic [6:0] exp_ctrl(input bit h, input logic [5:0] o,
                                            input bit zz, input bit rs);
        if (h)                   return {rs, 6'b000000};
        if (o[5])                return {4'b1011, o[4:2]};
        if (o[5:2] == 4'b0001)   return 7'b1110000;
        case (o)
            6'd2:    return 7'b0000000;
            6'd3:    return {~zz, 6'b000000};
            6'd8:    return {zz, 6'b000000};
            6'd15:   return 7'b0000000;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic bit op_illegal(input logic [5:0] o);
        return !(o[5] || (o[5:2] == 4'b0001) || o == 6'd0 || o == 6'd2 ||
                 o == 6'd3 || o == 6'd8 || o == 6'd15);
    endfunction

    bit m_valid = 1'b0;
    bit m_halted, m_ill_a, m_ill_b;
    int m_ret_a, m_ret_b, m_hc_a, m_hc_b;

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            m_halted = 1'b0;
            m_ill_a  = 1'b0;
            m_ill_b  = 1'b0;
            m_ret_a  = 0; m_ret_b = 0; m_hc_a = 0; m_hc_b = 0;
        end else if (!m_halted) begin
            m_ret_a = (m_ret_a < 65535) ? m_ret_a + 1 : 65535;
            m_ret_b = (m_ret_b < 15) ? m_ret_b + 1 : 15;
            m_ill_a = m_ill_a | op_illegal(opcode);
            m_ill_b = op_illegal(opcode);
            if (opcode == 6'b001111) m_halted = 1'b1;
        end else begin
            m_hc_a  = (m_hc_a < 65535) ? m_hc_a + 1 : 65535;
            m_hc_b  = (m_hc_b < 15) ? m_hc_b + 1 : 15;
            m_ill_b = 1'b0;
            if (resume) m_halted = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("ctrl_a",    32'(ctrl_a),    32'(exp_ctrl(m_halted, opcode, z, resume)));
            check("ctrl_b",    32'(ctrl_b),    32'(exp_ctrl(m_halted, opcode, z, resume)));
            check("halted_a",  32'(halted_a),  32'(m_halted));
            check("halted_b",  32'(halted_b),  32'(m_halted));
            check("illegal_a", 32'(illegal_a), 32'(m_ill_a));
            check("illegal_b", 32'(illegal_b), 32'(m_ill_b));
            check("retired_a", 32'(retired_a), 32'(m_ret_a));
            check("retired_b", 32'(retired_b), 32'(m_ret_b));
            check("hc_a",      32'(hc_a),      32'(m_hc_a));
            check("hc_b",      32'(hc_b),      32'(m_hc_b));
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [5:0] o, input logic zz, input logic rs);
        opcode = o; z = zz; resume = rs;
        #1;
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        check("rst_retired", 32'(retired_a), 0);
        check("rst_halted",  32'(halted_a),  0);
        check("rst_illegal", 32'(illegal_a), 0);

        set_in(6'b100100, 0, 0);
        check("alu_ctrl", 32'(ctrl_a), 32'h59);
        step(1);
        check("alu_retired", 32'(retired_a), 1);

        set_in(6'b000111, 0, 0);
        check("li_ctrl", 32'(ctrl_a), 32'h70);
        step(1);
        set_in(6'b000011, 1, 0); check("jz_z1", 32'(s_inc_a), 0); step(1);
        set_in(6'b000011, 0, 0); check("jz_z0", 32'(s_inc_a), 1); step(1);
        set_in(6'b001000, 1, 0); check("jnz_z1", 32'(s_inc_a), 1); step(1);
        set_in(6'b001000, 0, 0); check("jnz_z0", 32'(s_inc_a), 0); step(1);

        set_in(6'b001111, 0, 0);
        step(5);
        check("halt_halted",  32'(halted_a),  1);
        check("halt_cycles",  32'(hc_a),      4);
        check("halt_retired", 32'(retired_a), 7);
        check("halt_ctrl",    32'(ctrl_a),    0);

        set_in(6'b001111, 0, 1);
        check("resume_sinc", 32'(s_inc_a), 1);
        step(1);
        set_in(6'b000000, 0, 0);
        check("resume_halted", 32'(halted_a), 0);
        check("resume_hc",     32'(hc_a),     5);
        step(1);
        check("resume_retired", 32'(retired_a), 8);

        set_in(6'b000000, 0, 1); step(1);
        check("run_resume_ign", 32'(halted_a), 0);
        set_in(6'b001111, 0, 1); step(1);
        check("halt_with_resume", 32'(halted_a), 1);
        set_in(6'b000000, 0, 1); step(1);
        check("one_halt_cycle", 32'(hc_a), 6);
        check("left_halt",      32'(halted_a), 0);

        set_in(6'b010101, 0, 0);
        check("illegal_ctrl", 32'(ctrl_a), 32'h40);
        step(1);
        check("illegal_sticky_set", 32'(illegal_a), 1);
        check("illegal_pulse_set",  32'(illegal_b), 1);
        set_in(6'b000000, 0, 0); step(1);
        check("illegal_sticky_hold", 32'(illegal_a), 1);
        check("illegal_pulse_drop",  32'(illegal_b), 0);

        for (int i = 0; i < 64; i++) begin
            set_in(6'(i), 1'(i >> 3), 1'b1);
            step(1);
        end

        reset = 1'b1; set_in(6'b000000, 0, 0); step(1);
        reset = 1'b0;
        step(20);
        check("sat_retired_b", 32'(retired_b), 15);
        check("sat_retired_a", 32'(retired_a), 20);
        set_in(6'b010101, 0, 0); step(1);
        set_in(6'b001111, 0, 0); step(21);
        check("sat_hc_b", 32'(hc_b), 15);
        check("sat_hc_a", 32'(hc_a), 20);
        check("sat_halted", 32'(halted_b), 1);

        reset = 1'b1; set_in(6'b001111, 0, 1); step(1);
        check("rst_mid_halt_a", 32'(halted_a), 0);
        check("rst_mid_halt_b", 32'(halted_b), 0);
        check("rst_ret_a", 32'(retired_a), 0);
        check("rst_hc_a",  32'(hc_a), 0);
        check("rst_hc_b",  32'(hc_b), 0);
        check("rst_ill_a", 32'(illegal_a), 0);
        reset = 1'b0; set_in(6'b000000, 0, 0); step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_uc_fsm

`default_nettype wire

// File: doc/uc_fsm.md
Name: uc_fsm

Overview:
Control unit for the single-cycle microcontroller datapath, directly upstream of it.
- Consumes the 6-bit opcode (instruction[15:10]) and the registered Z flag from the datapath.
- Drives the datapath controls s_inc, s_inm, we3, wez and op.
- Adds a sequential RUN/HALT state machine with a resume handshake, a sticky illegal-opcode flag and saturating retired-instruction and halt-cycle counters for debug.

Parameters:
CNT_W, 16, width of retired and halt_cycles counters
ILLEGAL_STICKY, 1, 1 = illegal flag held until reset; 0 = flag is a one-cycle pulse

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instruction[15:10] from datapath
z  input  1  registered zero flag from datapath
resume  input  1  request to leave HALT, level sampled each clock
s_inc  output  1  1 = PC+1, 0 = load instruction[9:0]
s_inm  output  1  1 = write immediate instruction[11:4], 0 = write ALU result
we3  output  1  register file write enable
wez  output  1  Z flag write enable
op  output  3  ALU operation
halted  output  1  1 while in HALT state
illegal  output  1  illegal opcode seen
retired  output  CNT_W  instructions executed in RUN, saturating
halt_cycles  output  CNT_W  clocks spent in HALT, saturating

Behaviour:
Reset, synchronous:
- state=RUN; halted=0, illegal=0, retired=0, halt_cycles=0.
- Control outputs are combinational from state/opcode/z, so during reset they decode the current opcode.
- reset has priority over every other event, including mid-HALT and during resume.

Opcode decode in RUN (combinational, zero latency):
- 1ooo xx (opcode[5]=1), ALU: op=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
- 0001xx, LI: we3=1, s_inm=1, wez=0, s_inc=1, op=000.
- 000000, NOP: we3=0, wez=0, s_inc=1.
- 000010, J: s_inc=0, no writes.
- 000011, JZ: s_inc = ~z, no writes.
- 001000, JNZ: s_inc = z, no writes.
- 001111, HALT: s_inc=0, no writes. The assembler rule is that the HALT address field equals its own address, so the PC stays put. Next state=HALT.
- Any other opcode: executes as NOP (s_inc=1, no writes). Asserts illegal next cycle: sticky or one-cycle pulse per ILLEGAL_STICKY.
- Default op=000 and s_inm=0 for all non-ALU/non-LI opcodes.

HALT state:
- we3=0, wez=0, s_inc=0. The PC reloads the HALT field and stays on the HALT instruction.
- halted=1.
- halt_cycles increments each HALT clock.
- resume=1 in HALT: this cycle s_inc=1 (PC advances past HALT), no writes; next state=RUN; halted drops next cycle.
- resume in RUN: ignored, including the cycle HALT is decoded. HALT is always entered and at least one HALT cycle occurs.

Counters:
- retired increments on every RUN cycle, including J/JZ/JNZ/HALT/illegal.
- retired does not increment on HALT-state cycles, including the resume cycle.
- Both counters saturate at all-ones; no wrap.

Timing:
- Outputs are valid within the same cycle as opcode.
- State, flags and counters update on the clock edge; no handshake latency beyond 1 cycle.

Decomposition:
- Shared package uc_pkg holds:
  - opcode constants OP_NOP, OP_J, OP_JZ, OP_JNZ, OP_HALT, LI prefix 4'b0001, ALU prefix bit;
  - state enum {RUN, HALT};
  - ALU op width constant 3.
- One natural sub-module: uc_decode, purely combinational opcode/z -> {s_inc, s_inm, we3, wez, op, is_halt, is_illegal}.
- uc_fsm instantiates uc_decode and adds the state, override and counter logic.

Test Plan:
- Reset, then opcode=100100 (ALU op 001) -> s_inc=1, we3=1, wez=1, s_inm=0, op=001; retired=1 after the clock.
- opcode=000111 (LI) -> we3=1, s_inm=1, wez=0; opcode=000011 with z=1 -> s_inc=0; with z=0 -> s_inc=1; JNZ is the inverse.
- opcode=001111 held for 5 clocks, resume=0 -> halted=1 from cycle 2, we3=wez=s_inc=0, halt_cycles=4, retired frozen.
- resume=1 for 1 cycle in HALT -> s_inc=1 that cycle, halted=0 next, retired resumes counting; resume during RUN -> no effect.
- opcode=010101 (illegal) -> no writes, s_inc=1, illegal=1 next cycle and held (ILLEGAL_STICKY=1); pulse only with ILLEGAL_STICKY=0.
- CNT_W=4, 20 NOPs -> retired=15 saturated; then reset asserted while halted -> halted=0, counters 0, illegal 0 after the edge.
